// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants and PC helpers
//
// Purpose: XLEN, instruction alignment, canonical NOP and default reset PC
// shared by the fetch front end and its sub-blocks.
// Ports: none (package).
package core_pkg;

  localparam int XLEN       = 32;
  localparam int INST_ALIGN = 4;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are word aligned; low bits of any target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, push/pop, full/empty/count
//
// Purpose: small register-based FIFO; DEPTH must be a power of two >= 2.
// Ports:
//   CLK, RESET       clock, synchronous active-high reset
//   FLUSH            synchronous clear (wins over push/pop)
//   PUSH, PUSH_DATA  write request and data
//   POP, POP_DATA    read request, head data (valid when !EMPTY)
//   FULL, EMPTY      occupancy flags
//   COUNT            number of stored entries
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FLUSH,
  input  logic                       PUSH,
  input  logic [WIDTH-1:0]           PUSH_DATA,
  input  logic                       POP,
  output logic [WIDTH-1:0]           POP_DATA,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign EMPTY    = (count == '0);
  assign FULL     = (count == CW'(DEPTH));
  assign COUNT    = count;
  assign POP_DATA = mem[rd_ptr];

  assign do_pop  = POP && !EMPTY;
  // Pushing into a full FIFO is fine when the head leaves in the same cycle:
  // wr_ptr == rd_ptr then, and the old head is read before it is overwritten.
  assign do_push = PUSH && (!FULL || do_pop);

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !FLUSH) mem[wr_ptr] <= PUSH_DATA;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction fetch front end with prefetch queue
//
// Purpose: issues sequential fetches to instruction memory, buffers returned
// words tagged with their PC, and hands them to decode over valid/ready.
// A redirect flushes the buffer, drops in-flight responses and refetches.
// Optional macro FETCH_BYPASS_EN: a response arriving while the queue is
// empty drives the output in the same cycle.
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   REDIRECT, REDIRECT_PC      flush and restart fetch at REDIRECT_PC
//   IMEM_REQ, IMEM_ADDR        fetch request and word-aligned address
//   IMEM_GNT                   request accepted this cycle
//   IMEM_RVALID, IMEM_RDATA    in-order response
//   OUT_VALID, OUT_READY       decode handshake
//   OUT_INST, OUT_PC           head instruction and its PC
module fetch_prefetch_queue
  import core_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_INST,
  output logic [XLEN-1:0] OUT_PC
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = CW + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   pc_tag;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [2*XLEN-1:0] fifo_head;
  logic [SW-1:0]     credit_used;
  logic              grant;
  logic              live_rsp;
  logic              bypass;
  logic              bypass_take;
  logic              push;
  logic              pop_fifo;
  logic [2*XLEN-1:0] head;

  // outstanding counts every fetch still in flight, dropped ones included,
  // so buffered + outstanding never exceeds the FIFO capacity.
  assign credit_used = SW'(fifo_count) + SW'(outstanding);
  assign IMEM_REQ    = !RESET && !REDIRECT && (credit_used < SW'(DEPTH));
  assign IMEM_ADDR   = fetch_pc;
  assign grant       = IMEM_REQ && IMEM_GNT;

  // A response belongs to the current path only when nothing older is still
  // waiting to be dropped; a redirect in the same cycle kills it as well.
  assign live_rsp = !RESET && !REDIRECT && IMEM_RVALID && (discard == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass      = live_rsp && fifo_empty;
  assign bypass_take = bypass && OUT_READY;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign pop_fifo = !RESET && !REDIRECT && !fifo_empty && OUT_READY;
  assign push     = live_rsp && !bypass_take && (!fifo_full || pop_fifo);

  assign head      = bypass ? {IMEM_RDATA, pc_tag} : fifo_head;
  assign OUT_VALID = !RESET && (!fifo_empty || bypass);
  assign OUT_INST  = OUT_VALID ? head[2*XLEN-1:XLEN] : '0;
  assign OUT_PC    = OUT_VALID ? head[XLEN-1:0] : '0;

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (REDIRECT),
    .PUSH      (push),
    .PUSH_DATA ({IMEM_RDATA, pc_tag}),
    .POP       (pop_fifo),
    .POP_DATA  (fifo_head),
    .FULL      (fifo_full),
    .EMPTY     (fifo_empty),
    .COUNT     (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc    <= align_pc(RESET_PC);
      pc_tag      <= align_pc(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(IMEM_RVALID);
      if (REDIRECT) begin
        fetch_pc <= align_pc(REDIRECT_PC);
        pc_tag   <= align_pc(REDIRECT_PC);
        // Every fetch still in flight after this cycle is stale. Live
        // in-flight (outstanding - discard) plus the already-pending discard
        // collapses to outstanding, less the response consumed right now.
        discard  <= outstanding - CW'(IMEM_RVALID);
      end else begin
        if (grant)                          fetch_pc <= fetch_pc + XLEN'(INST_ALIGN);
        if (live_rsp)                       pc_tag   <= pc_tag + XLEN'(INST_ALIGN);
        if (IMEM_RVALID && discard != '0)   discard  <= discard - CW'(1);
      end
    end
  end

endmodule
